// File: rtl/downcounter_timer.sv
// rtl/downcounter_timer.sv - loadable down-counting timer with done pulse and optional auto-reload
//
// Ports:
//   clock       in   1      rising-edge clock
//   reset       in   1      synchronous, active-high
//   load_valid  in   1      start-count offer
//   load_ready  out  1      high in IDLE; a load is accepted when both are high
//   load_value  in   WIDTH  start count, sampled on a load handshake
//   enable      in   1      count-step qualifier (RUN only)
//   abort       in   1      cancel the current count (RUN and DONE)
//   countValue  out  WIDTH  remaining count, registered
//   busy        out  1      high in RUN and DONE
//   done        out  1      one-cycle completion pulse (state DONE)
module downcounter_timer #(
    parameter int WIDTH       = 10,
    parameter int DECREMENT   = 1,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] countValue,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(DECREMENT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             load_ready_q, busy_q, done_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    count_d  = load_value;
                    reload_d = load_value;
                    state_d  = (load_value != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (enable) begin
                    // Saturate at zero instead of wrapping when the step
                    // overshoots the remaining count.
                    if (count_q <= STEP) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q - STEP;
                    end
                end
            end
            DONE: begin
                if (!abort && (AUTO_RELOAD != 0) && (reload_q != '0)) begin
                    count_d = reload_q;
                    state_d = RUN;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Status outputs are registered alongside the state so they never see
    // a combinational path from any input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            reload_q     <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            reload_q     <= reload_d;
            load_ready_q <= (state_d == IDLE);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
        end
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign countValue = count_q;

endmodule
